// File: rtl/zion_pcl_fetch_responder.sv
// zion_pcl_fetch_responder: issues instruction-memory reads for fetch requests and buffers
// PC-tagged results for decode; a PC-set flush discards all buffered and in-flight work.
module zion_pcl_fetch_responder #(
  parameter int          ADDR_W   = 12,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iFetchEn,
  input  logic [31:0]       iPc,
  input  logic              iFlush,
  output logic              oFetchRdy,
  output logic              oMemRdEn,
  output logic [ADDR_W-1:0] oMemAddr,
  input  logic [31:0]       iMemRdData,
  output logic              oInstVld,
  output logic [31:0]       oInst,
  output logic [31:0]       oInstPc,
  output logic              oInstErr,
  input  logic              iDecRdy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;
  logic [CW-1:0] count;
  logic [PW-1:0] wrPtr, rdPtr;
  logic          inflightVld, inflightErr;
  logic [31:0]   inflightPc;
  logic [31:0]   instMem [DEPTH];
  logic [31:0]   pcMem [DEPTH];
  logic          errMem [DEPTH];
  logic          accept, push, pop;
  logic [OW-1:0] occ;
  // Readiness counts the in-flight slot so a returning word always has room.
  always_comb begin
    occ       = {1'b0, count} + OW'(inflightVld);
    oFetchRdy = ~rst & (occ < OW'(DEPTH));
    accept    = iFetchEn & oFetchRdy & ~iFlush;
    oMemRdEn  = accept & (iPc[1:0] == 2'b00);
    oMemAddr  = iPc[ADDR_W+1:2];
    push      = inflightVld & ~iFlush;
    oInstVld  = (count != '0) & ~iFlush & ~rst;
    pop       = oInstVld & iDecRdy;
    oInst     = instMem[rdPtr];
    oInstPc   = pcMem[rdPtr];
    oInstErr  = oInstVld & errMem[rdPtr];
  end
  always_ff @(posedge clk) begin
    if (rst || iFlush) begin
      count       <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      inflightVld <= 1'b0;
    end else begin
      count       <= count + CW'(push) - CW'(pop);
      wrPtr       <= wrPtr + PW'(push);
      rdPtr       <= rdPtr + PW'(pop);
      inflightVld <= accept;
      if (accept) begin
        inflightPc  <= iPc;
        inflightErr <= iPc[1:0] != 2'b00;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instMem[wrPtr] <= inflightErr ? NOP_INST : iMemRdData;
      pcMem[wrPtr]   <= inflightPc;
      errMem[wrPtr]  <= inflightErr;
    end
  end
endmodule

// File: doc/zion_pcl_fetch_responder.md
# zion_pcl_fetch_responder

Instruction-side responder for the fetch stage. It accepts the fetch stage's per-cycle request (fetch enable plus PC) and issues word reads to a synchronous instruction memory with one cycle of read latency. Returned instructions are buffered, tagged with their PC, and presented to decode through a valid/ready handshake. A branch/jump PC-set event flushes all stale work. It sits between the PC generator/fetch unit and the decode stage.

## Interface
- ADDR_W, 12 — word-address width of the instruction memory (memory holds 2^ADDR_W words).
- DEPTH, 4 — return-buffer entries; legal values are 2, 4 or 8. Full throughput requires DEPTH ≥ 3.
- NOP_INST, 32'h0000_0013 — instruction word substituted for misaligned requests.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- iFetchEn  in  1  fetch request valid.
- iPc  in  32  request PC.
- iFlush  in  1  PC-set (branch/jump) event; same-cycle copy of the set channel's enable.
- oFetchRdy  out  1  responder can accept a request this cycle.
- oMemRdEn  out  1  memory read strobe.
- oMemAddr  out  ADDR_W  word address, iPc[ADDR_W+1:2].
- iMemRdData  in  32  read data; valid the cycle after oMemRdEn.
- oInstVld  out  1  decode output valid.
- oInst  out  32  instruction word.
- oInstPc  out  32  PC of oInst.
- oInstErr  out  1  oInst came from a misaligned request.
- iDecRdy  in  1  decode accepts the head entry.

## Operation
- accept = iFetchEn & oFetchRdy & ~iFlush & ~rst.
- oFetchRdy = (count + inflightVld) < DEPTH. It depends on state only, with no combinational path from iDecRdy.
- On accept with iPc[1:0]==0:
  - drive oMemRdEn=1 and oMemAddr from iPc;
  - set inflightVld, inflightPc=iPc, inflightErr=0.
- On accept with iPc[1:0]!=0:
  - oMemRdEn=0;
  - set inflightVld, inflightPc=iPc, inflightErr=1.
- Cycle after accept (inflightVld=1): push {inflightPc, inflightErr ? NOP_INST : iMemRdData, inflightErr} into the FIFO, then clear inflightVld unless a new accept occurs the same cycle.
- oInstVld = (count != 0) & ~iFlush. oInst, oInstPc and oInstErr are the FIFO head.
- pop = oInstVld & iDecRdy. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Flush (iFlush=1):
  - count and pointers cleared, inflightVld cleared; a pending push is discarded, and the next cycle's iMemRdData is ignored;
  - no accept and no pop in that cycle;
  - next cycle oFetchRdy=1 and oInstVld=0.
- Simultaneous flush and push: the flush wins.
- oMemAddr is don't-care when oMemRdEn=0; the implementation drives iPc bits regardless.

## Timing
- Reset (rst=1, sampled at the edge):
  - count=0, pointers=0, inflightVld=0;
  - during and after the reset cycle: oInstVld=0, oMemRdEn=0, oFetchRdy=1 (gated low only while rst=1), oInstErr=0.
- Latency: request accepted at cycle T → memory read at T → data pushed at end of T+1 → oInstVld=1 at T+2.
- Throughput: one instruction per cycle when iDecRdy is held high and DEPTH ≥ 3.
- Order: instructions are delivered strictly in acceptance order.
- Backpressure:
  - with iDecRdy=0, the FIFO fills;
  - oFetchRdy drops once count+inflightVld == DEPTH;
  - no entry is ever overwritten or dropped except by flush or reset.
- Reset mid-operation behaves exactly as a flush, plus it forces accept=0 in the reset cycle.

## Test plan
- Reset, then iFetchEn=1 with PC 0x0,0x4,0x8,0xC and memory word n = 0xA000_0000+n, iDecRdy=1 → oInstVld rises 2 cycles after the first accept; the four instructions arrive on consecutive cycles with matching oInstPc; oFetchRdy stays 1.
- Continuous requests with iDecRdy=0, DEPTH=4 → exactly 4 accepts (3 in FIFO plus 1 in flight, then 4 in FIFO), then oFetchRdy=0. Raise iDecRdy → head PC 0x0 pops first; no loss or duplication.
- Flush asserted on the cycle the PC-0x8 data returns, with 0x0 and 0x4 buffered → next cycle oInstVld=0 and count=0. A new request at 0x100 is delivered next, with no stale 0x0, 0x4 or 0x8.
- Request at PC 0x6 → oMemRdEn=0; two cycles later oInst=0x0000_0013, oInstErr=1, oInstPc=0x6.
- rst pulsed for one cycle while the FIFO holds 2 entries and a read is in flight → after reset oInstVld=0 and oFetchRdy=1, and the late iMemRdData is not pushed.
- iFlush and iFetchEn together at PC 0x20 → no accept and oMemRdEn=0. The same PC offered the next cycle is accepted and delivered.
